memory_dumper: RTL and testbench

- Reads a contiguous range of words from a memory read port and streams them out through the UART transmit-side byte handshake.
- It is the transmit-direction counterpart of the program loader, which writes memory from received UART bytes.
- Typical use: dumping main memory results to the host after the core halts.
- Sits between a memory `out_*` port and the UART `in_*` port; the top-level arbitrates shared ports.

---
 rtl/memory_dumper.sv | 150 +++++++++++++++
 tb/tb_memory_dumper.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_dumper.sv
// Streams a contiguous range of memory words out through the UART byte handshake,
// optionally preceded by a little-endian 32-bit word-count header.
//
// state   | meaning
// IDLE    | waiting for start; latches address and count
// HDR     | sending the 4 header bytes (latched word count)
// CHECK   | decides between another word and finishing
// REQ     | one-cycle memory read strobe
// WAIT    | waiting for the read response
// SEND    | sending the 4 bytes of the fetched word
// DONE    | one-cycle done pulse, then back to IDLE
module memory_dumper #(
    parameter int SEND_HEADER = 1,
    parameter int ADDR_STEP   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [31:0] word_count,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_out_addr,
    output logic        mem_out_valid,
    input  logic [31:0] mem_out_data,
    input  logic        mem_out_ready,
    output logic [7:0]  uart_in_data,
    output logic        uart_in_valid,
    input  logic        uart_in_ready
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] addr;
    logic [31:0] remaining;
    logic [31:0] count_buf;
    logic [31:0] word_buf;
    logic [1:0]  byte_idx;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            addr          <= '0;
            remaining     <= '0;
            count_buf     <= '0;
            word_buf      <= '0;
            byte_idx      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_out_addr  <= '0;
            mem_out_valid <= 1'b0;
            uart_in_data  <= '0;
            uart_in_valid <= 1'b0;
        end else begin
            done          <= 1'b0;
            mem_out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= word_count;
                        count_buf <= word_count;
                        byte_idx  <= '0;
                        busy      <= 1'b1;
                        if (SEND_HEADER != 0) begin
                            uart_in_valid <= 1'b1;
                            uart_in_data  <= word_count[7:0];
                            state         <= S_HDR;
                        end else begin
                            state <= S_CHECK;
                        end
                    end
                end
                // uart_in_valid is held high for the whole of HDR and SEND
                S_HDR: begin
                    if (uart_in_ready) begin
                        if (byte_idx == 2'd3) begin
                            uart_in_valid <= 1'b0;
                            state         <= S_CHECK;
                        end else begin
                            byte_idx     <= byte_idx + 2'd1;
                            uart_in_data <= pick_byte(count_buf, byte_idx + 2'd1);
                        end
                    end
                end
                S_CHECK: begin
                    if (remaining == 32'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        mem_out_valid <= 1'b1;
                        mem_out_addr  <= addr;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_out_ready) begin
                        word_buf      <= mem_out_data;
                        byte_idx      <= '0;
                        uart_in_valid <= 1'b1;
                        uart_in_data  <= mem_out_data[7:0];
                        state         <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (uart_in_ready) begin
                        if (byte_idx == 2'd3) begin
                            uart_in_valid <= 1'b0;
                            addr          <= addr + STEP;
                            remaining     <= remaining - 32'd1;
                            state         <= S_CHECK;
                        end else begin
                            byte_idx     <= byte_idx + 2'd1;
                            uart_in_data <= pick_byte(word_buf, byte_idx + 2'd1);
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_dumper.sv
// Self-checking bench for memory_dumper: two instances (header/word-step and
// headerless/byte-step) driven by randomized UART and memory responders.
module tb_memory_dumper;

    logic clk = 1'b0;
    logic reset;
    logic [1:0]       start_s;
    logic [1:0][31:0] saddr_s, wcnt_s, maddr_s, mdata_s;
    logic [1:0]       busy_s, done_s, mvalid_s, mready_s, uvalid_s, uready_s;
    logic [1:0][7:0]  udata_s;

    memory_dumper #(.SEND_HEADER(1), .ADDR_STEP(1)) u_hdr (
        .clk(clk), .reset(reset), .start(start_s[0]), .start_addr(saddr_s[0]),
        .word_count(wcnt_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .mem_out_addr(maddr_s[0]), .mem_out_valid(mvalid_s[0]),
        .mem_out_data(mdata_s[0]), .mem_out_ready(mready_s[0]),
        .uart_in_data(udata_s[0]), .uart_in_valid(uvalid_s[0]), .uart_in_ready(uready_s[0])
    );

    memory_dumper #(.SEND_HEADER(0), .ADDR_STEP(4)) u_raw (
        .clk(clk), .reset(reset), .start(start_s[1]), .start_addr(saddr_s[1]),
        .word_count(wcnt_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .mem_out_addr(maddr_s[1]), .mem_out_valid(mvalid_s[1]),
        .mem_out_data(mdata_s[1]), .mem_out_ready(mready_s[1]),
        .uart_in_data(udata_s[1]), .uart_in_valid(uvalid_s[1]), .uart_in_ready(uready_s[1])
    );

    int checks = 0;
    int passes = 0;
    int cur = 0;
    int rdy_pct = 100;
    int lat = 1;
    bit spurious = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [7:0]  got_bytes[$];
    logic [31:0] got_addrs[$];
    logic [31:0] mem_ovr[logic [31:0]];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory contents: directed overrides, otherwise a fixed scramble of the address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[7:0] ^ 8'h3C, a[31:24] + 8'h71, a[15:8] ^ 8'hE4, a[23:16] + 8'h2B};
    endfunction

    // UART sink and memory responder for the unit under test, acting on the falling edge.
    initial begin
        logic [7:0]  prev_data;
        logic [31:0] paddr;
        bit prev_pend, pend, r;
        int cnt;
        prev_pend = 0; pend = 0; cnt = 0; paddr = '0; prev_data = '0;
        uready_s = '0; mready_s = '0; mdata_s = '0;
        forever begin
            @(negedge clk);
            uready_s = '0;
            mready_s = '0;
            mdata_s  = '0;
            mdata_s[cur] = $urandom;
            if (reset) begin
                prev_pend = 0;
                pend = 0;
            end else begin
                if (prev_pend) begin
                    chk("uart_valid_hold", 32'(uvalid_s[cur]), 32'd1);
                    chk("uart_data_hold", 32'(udata_s[cur]), 32'(prev_data));
                end
                r = ($urandom_range(99) < rdy_pct);
                uready_s[cur] = r;
                if (uvalid_s[cur] && r) got_bytes.push_back(udata_s[cur]);
                prev_pend = uvalid_s[cur] && !r;
                prev_data = udata_s[cur];

                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        mready_s[cur] = 1'b1;
                        mdata_s[cur]  = mem_val(paddr);
                        pend = 0;
                    end
                end
                if (spurious) begin
                    mready_s[cur] = 1'b1;
                    mdata_s[cur]  = 32'hDEADBEEF;
                    spurious = 0;
                end
                if (mvalid_s[cur]) begin
                    got_addrs.push_back(maddr_s[cur]);
                    paddr = maddr_s[cur];
                    pend = 1;
                    cnt = lat;
                end
                if (done_s[cur]) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("busy_in_done", 32'(busy_s[cur]), 32'd1);
                end
            end
        end
    end

    task automatic run(input int u, input logic [31:0] sa, input logic [31:0] n,
                       input string tag, input bit inject, input int abort_at);
        logic [7:0]  exp_b[$];
        logic [31:0] exp_a[$];
        logic [31:0] step, a, w;
        bit hdr, timed, injected;
        int t0, bound, nb, na;
        hdr = (u == 0);
        step = (u == 0) ? 32'd1 : 32'd4;
        timed = (rdy_pct == 100) && (lat == 1);
        injected = 0;
        if (hdr) for (int k = 0; k < 4; k++) exp_b.push_back(n[8*k +: 8]);
        for (int i = 0; i < int'(n); i++) begin
            a = sa + step * 32'(i);
            exp_a.push_back(a);
            w = mem_val(a);
            for (int k = 0; k < 4; k++) exp_b.push_back(w[8*k +: 8]);
        end

        @(posedge clk); #1;
        cur = u;
        got_bytes.delete();
        got_addrs.delete();
        done_cnt = 0;
        saddr_s[u] = sa;
        wcnt_s[u] = n;
        start_s[u] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        chk({tag, "_busy_pre"}, 32'(busy_s[u]), 32'd0);
        @(posedge clk); #1;
        start_s[u] = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy_s[u]), 32'd1);

        bound = 0;
        while (done_cnt == 0 && bound < 3000) begin
            @(posedge clk); #1;
            bound++;
            start_s[u] = 1'b0;
            if (inject && !injected && got_bytes.size() >= 5) begin
                start_s[u] = 1'b1;
                saddr_s[u] = $urandom;
                wcnt_s[u] = 32'($urandom_range(9, 1));
                injected = 1;
            end
            if (abort_at > 0 && got_bytes.size() >= abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk({tag, "_rst_busy"}, 32'(busy_s[u]), 32'd0);
                chk({tag, "_rst_uvalid"}, 32'(uvalid_s[u]), 32'd0);
                chk({tag, "_rst_mvalid"}, 32'(mvalid_s[u]), 32'd0);
                chk({tag, "_rst_done"}, 32'(done_s[u]), 32'd0);
                repeat (8) @(posedge clk);
                #1;
                chk({tag, "_no_done"}, 32'(done_cnt), 32'd0);
                return;
            end
        end
        chk({tag, "_finished"}, 32'(done_cnt > 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy_s[u]), 32'd0);
        if (timed) chk({tag, "_latency"}, 32'(done_cyc - t0), 32'(2 + (hdr ? 4 : 0)) + 32'd7 * n);
        chk({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_b.size()));
        chk({tag, "_nreqs"}, 32'(got_addrs.size()), 32'(exp_a.size()));
        nb = (got_bytes.size() < exp_b.size()) ? got_bytes.size() : exp_b.size();
        na = (got_addrs.size() < exp_a.size()) ? got_addrs.size() : exp_a.size();
        for (int i = 0; i < nb; i++) chk({tag, "_byte"}, 32'(got_bytes[i]), 32'(exp_b[i]));
        for (int i = 0; i < na; i++) chk({tag, "_addr"}, got_addrs[i], exp_a[i]);
    endtask

    initial begin
        reset = 1'b1;
        start_s = '0;
        saddr_s = '0;
        wcnt_s = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", 32'(busy_s[u]), 32'd0);
            chk("rst_done", 32'(done_s[u]), 32'd0);
            chk("rst_mvalid", 32'(mvalid_s[u]), 32'd0);
            chk("rst_maddr", maddr_s[u], 32'd0);
            chk("rst_uvalid", 32'(uvalid_s[u]), 32'd0);
            chk("rst_udata", 32'(udata_s[u]), 32'd0);
        end
        reset = 1'b0;

        mem_ovr[32'h10] = 32'h11223344;
        mem_ovr[32'h11] = 32'hA0B0C0D0;
        rdy_pct = 100; lat = 1;
        run(0, 32'h10, 32'd2, "hdr2", 0, 0);

        rdy_pct = 50;
        run(0, $urandom, 32'd3, "backpressure", 0, 0);

        rdy_pct = 70; lat = 5;
        @(posedge clk); #1;
        cur = 0;
        spurious = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("spurious_idle_busy", 32'(busy_s[0]), 32'd0);
        run(0, $urandom, 32'd3, "latency5", 0, 0);

        rdy_pct = 100; lat = 1;
        run(1, $urandom, 32'd0, "zero_raw", 0, 0);
        run(0, $urandom, 32'd0, "zero_hdr", 0, 0);

        run(0, 32'h200, 32'd3, "abort", 0, 6);
        run(0, 32'h200, 32'd3, "replay", 0, 0);

        run(1, 32'hFFFFFFFC, 32'd2, "wrap", 0, 0);

        rdy_pct = 60;
        run(0, $urandom, 32'd4, "start_busy", 1, 0);

        for (int it = 0; it < 6; it++) begin
            rdy_pct = $urandom_range(100, 30);
            lat = $urandom_range(4, 1);
            run(it % 2, $urandom, 32'($urandom_range(5, 1)), "random", 0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
